// File: rtl/usb_rx_pkt_checker_if.sv
// Bus bundle for the USB receive packet checker: serial bit input with
// ready/avail flow control, end-of-packet strobe, and the held result with
// its output handshake.
interface usb_rx_pkt_checker_if #(
  parameter int MAX_DATA_BYTES = 8
);
  localparam int PKT_W = 8 * MAX_DATA_BYTES + 24;
  localparam int LEN_W = $clog2(PKT_W + 1);

  logic             bit_in;
  logic             bit_in_avail;
  logic             ready_in;
  logic             eop;
  logic [PKT_W-1:0] pkt;
  logic [LEN_W-1:0] pkt_len;
  logic             pkt_out_avail;
  logic             out_ready;
  logic             valid;
  logic [2:0]       err;

  // Producer/consumer side (drives bits, eop and accepts results)
  modport master (
    output bit_in, bit_in_avail, eop, out_ready,
    input  ready_in, pkt, pkt_len, pkt_out_avail, valid, err
  );

  // Checker side
  modport slave (
    input  bit_in, bit_in_avail, eop, out_ready,
    output ready_in, pkt, pkt_len, pkt_out_avail, valid, err
  );
endinterface

// File: rtl/usb_rx_pkt_checker.sv
// USB receive packet checker. Assembles an unstuffed LSB-first bit stream
// into a buffer, classifies it by PID, runs CRC5/CRC16 on the fly, and holds
// the packet with length, valid flag and error code until the consumer
// takes it.
module usb_rx_pkt_checker #(
  parameter int MAX_DATA_BYTES = 8
) (
  input logic                 clk,
  input logic                 rst,
  usb_rx_pkt_checker_if.slave bus
);
  localparam int PKT_W = 8 * MAX_DATA_BYTES + 24;
  localparam int LEN_W = $clog2(PKT_W + 1);

  localparam logic [4:0]  CRC5_POLY = 5'h05;
  localparam logic [4:0]  CRC5_RES  = 5'h0C;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_RES  = 16'h800D;

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_PID  = 3'd1;
  localparam logic [2:0] ERR_CRC  = 3'd2;
  localparam logic [2:0] ERR_LEN  = 3'd3;
  localparam logic [2:0] ERR_OVF  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic b);
    logic fb;
    fb = crc[4] ^ b;
    return {crc[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'h00);
  endfunction

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

  // First matching rule wins: overflow, length, PID, CRC.
  function automatic logic [2:0] eval_err(
    input logic [LEN_W-1:0] len,
    input logic [7:0]       pid_byte,
    input logic             ovf,
    input logic [4:0]       crc5,
    input logic [15:0]      crc16
  );
    logic len_bad;
    logic pid_bad;
    logic crc_bad;
    case (pid_byte[1:0])
      2'b01: begin
        len_bad = (len != LEN_W'(24));
        crc_bad = (crc5 != CRC5_RES);
      end
      2'b10: begin
        len_bad = (len != LEN_W'(8));
        crc_bad = 1'b0;
      end
      2'b11: begin
        // (len-8) is a whole number of bytes exactly when len[2:0] is zero
        len_bad = (len < LEN_W'(24)) || (len[2:0] != 3'd0);
        crc_bad = (crc16 != CRC16_RES);
      end
      default: begin
        len_bad = 1'b0;
        crc_bad = 1'b0;
      end
    endcase
    pid_bad = (pid_byte[3:0] != ~pid_byte[7:4]) || (pid_byte[1:0] == 2'b00);
    if (ovf) begin
      return ERR_OVF;
    end else if ((len < LEN_W'(8)) || len_bad) begin
      return ERR_LEN;
    end else if (pid_bad) begin
      return ERR_PID;
    end else if (crc_bad) begin
      return ERR_CRC;
    end else begin
      return ERR_NONE;
    end
  endfunction

  state_t           state_q, state_d;
  logic [PKT_W-1:0] pkt_q, pkt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic [4:0]       crc5_q, crc5_d;
  logic [15:0]      crc16_q, crc16_d;
  logic [2:0]       err_q, err_d;
  logic             valid_q, valid_d;
  logic             avail_q, avail_d;
  logic             ready_q, ready_d;
  logic             take_s;

  // Next-state and datapath: bit capture, CRC update, error evaluation at eop
  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    crc5_d  = crc5_q;
    crc16_d = crc16_q;
    err_d   = err_q;
    valid_d = valid_q;
    avail_d = avail_q;
    ready_d = ready_q;
    take_s  = bus.bit_in_avail && ready_q;

    case (state_q)
      S_IDLE: begin
        // eop without any bit is ignored here
        if (take_s) begin
          pkt_d[0] = bus.bit_in;
          len_d    = LEN_W'(1);
          state_d  = S_RECV;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RECV: begin
        // A bit arriving with eop is stored before the packet is judged
        if (take_s) begin
          if (len_q == LEN_W'(PKT_W)) begin
            ovf_d = 1'b1;
          end else begin
            pkt_d[len_q] = bus.bit_in;
            len_d        = len_q + LEN_W'(1);
            // PID byte is complete once 8 bits are stored; its class picks the CRC
            if (len_q >= LEN_W'(8)) begin
              case (pkt_q[1:0])
                2'b01:   crc5_d  = crc5_step(crc5_q, bus.bit_in);
                2'b11:   crc16_d = crc16_step(crc16_q, bus.bit_in);
                default: crc5_d  = crc5_q;
              endcase
            end else begin
              crc5_d = crc5_q;
            end
          end
        end else begin
          len_d = len_q;
        end
        if (bus.eop) begin
          err_d   = eval_err(len_d, pkt_d[7:0], ovf_d, crc5_d, crc16_d);
          valid_d = (err_d == ERR_NONE);
          avail_d = 1'b1;
          ready_d = 1'b0;
          state_d = S_HOLD;
        end else begin
          state_d = S_RECV;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
          pkt_d   = {PKT_W{1'b0}};
          len_d   = {LEN_W{1'b0}};
          ovf_d   = 1'b0;
          crc5_d  = 5'h1F;
          crc16_d = 16'hFFFF;
          err_d   = ERR_NONE;
          valid_d = 1'b0;
          avail_d = 1'b0;
          ready_d = 1'b1;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
        pkt_d   = {PKT_W{1'b0}};
        len_d   = {LEN_W{1'b0}};
        ovf_d   = 1'b0;
        crc5_d  = 5'h1F;
        crc16_d = 16'hFFFF;
        err_d   = ERR_NONE;
        valid_d = 1'b0;
        avail_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pkt_q   <= {PKT_W{1'b0}};
      len_q   <= {LEN_W{1'b0}};
      ovf_q   <= 1'b0;
      crc5_q  <= 5'h1F;
      crc16_q <= 16'hFFFF;
      err_q   <= ERR_NONE;
      valid_q <= 1'b0;
      avail_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      crc5_q  <= crc5_d;
      crc16_q <= crc16_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      avail_q <= avail_d;
      ready_q <= ready_d;
    end
  end

  assign bus.ready_in      = ready_q;
  assign bus.pkt           = pkt_q;
  assign bus.pkt_len       = len_q;
  assign bus.pkt_out_avail = avail_q;
  assign bus.valid         = valid_q;
  assign bus.err           = err_q;
endmodule

// File: tb/tb_usb_rx_pkt_checker.sv
// Directed bench for usb_rx_pkt_checker: handshake, token, data, error and
// flow-control cases with hand-derived expected results.
module tb_usb_rx_pkt_checker;
  localparam int MDB   = 8;
  localparam int PKT_W = 8 * MDB + 24;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  logic [PKT_W-1:0] exp_pkt;
  int               exp_len;

  usb_rx_pkt_checker_if #(.MAX_DATA_BYTES(MDB)) bus ();

  usb_rx_pkt_checker #(.MAX_DATA_BYTES(MDB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_bit(input logic b);
    if (exp_len < PKT_W) begin
      exp_pkt[exp_len] = b;
      exp_len++;
    end
  endtask

  task automatic send_bit(input logic b);
    bus.bit_in       = b;
    bus.bit_in_avail = 1'b1;
    @(posedge clk);
    #1;
    bus.bit_in_avail = 1'b0;
    bus.bit_in       = 1'b0;
    model_bit(b);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic send_eop();
    bus.eop = 1'b1;
    @(posedge clk);
    #1;
    bus.eop = 1'b0;
  endtask

  task automatic check_result(input string tag, input int len, input logic vld, input logic [2:0] e);
    chk({tag, ".avail"}, 128'(bus.pkt_out_avail), 128'(1'b1));
    chk({tag, ".ready"}, 128'(bus.ready_in), 128'(1'b0));
    chk({tag, ".len"},   128'(bus.pkt_len), 128'(len));
    chk({tag, ".valid"}, 128'(bus.valid), 128'(vld));
    chk({tag, ".err"},   128'(bus.err), 128'(e));
    chk({tag, ".pkt"},   128'(bus.pkt), 128'(exp_pkt));
  endtask

  task automatic accept(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, ".acc_avail"}, 128'(bus.pkt_out_avail), 128'(1'b0));
    chk({tag, ".acc_ready"}, 128'(bus.ready_in), 128'(1'b1));
    chk({tag, ".acc_len"},   128'(bus.pkt_len), 128'(0));
    exp_pkt = '0;
    exp_len = 0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".ready"}, 128'(bus.ready_in), 128'(1'b1));
    chk({tag, ".avail"}, 128'(bus.pkt_out_avail), 128'(1'b0));
    chk({tag, ".len"},   128'(bus.pkt_len), 128'(0));
    chk({tag, ".pkt"},   128'(bus.pkt), 128'(0));
    chk({tag, ".valid"}, 128'(bus.valid), 128'(1'b0));
    chk({tag, ".err"},   128'(bus.err), 128'(0));
  endtask

  initial begin
    logic [7:0] data0 [11];
    logic [7:0] ack;
    n_cmp            = 0;
    n_fail           = 0;
    exp_pkt          = '0;
    exp_len          = 0;
    rst              = 1'b1;
    bus.bit_in       = 1'b0;
    bus.bit_in_avail = 1'b0;
    bus.eop          = 1'b0;
    bus.out_ready    = 1'b0;
    data0 = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    ack   = 8'hD2;

    // Reset state
    @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;

    // eop while idle is ignored
    send_eop();
    chk("idle_eop.avail", 128'(bus.pkt_out_avail), 128'(1'b0));

    // ACK with the last bit and eop together, consumer already ready
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send_bit(ack[i]);
    bus.bit_in       = ack[7];
    bus.bit_in_avail = 1'b1;
    bus.eop          = 1'b1;
    @(posedge clk);
    #1;
    bus.bit_in_avail = 1'b0;
    bus.eop          = 1'b0;
    model_bit(ack[7]);
    check_result("ack", 8, 1'b1, 3'd0);
    chk("ack.pkt_const", 128'(bus.pkt), 128'(88'hD2));
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("ack.idle_avail", 128'(bus.pkt_out_avail), 128'(1'b0));
    chk("ack.idle_ready", 128'(bus.ready_in), 128'(1'b1));
    exp_pkt = '0;
    exp_len = 0;

    // SETUP token, with an idle gap between bytes
    send_byte(8'h2D);
    @(posedge clk);
    #1;
    send_byte(8'h00);
    send_byte(8'h10);
    send_eop();
    check_result("setup", 24, 1'b1, 3'd0);
    chk("setup.pkt_const", 128'(bus.pkt), 128'(88'h10002D));
    accept("setup");

    // SETUP with its final CRC bit flipped
    send_byte(8'h2D);
    send_byte(8'h00);
    send_byte(8'h90);
    send_eop();
    check_result("setup_bad", 24, 1'b0, 3'd2);
    accept("setup_bad");

    // DATA0 with 8-byte payload and correct CRC16
    for (int i = 0; i < 11; i++) send_byte(data0[i]);
    send_eop();
    check_result("data0", 88, 1'b1, 3'd0);
    accept("data0");

    // Zero-length DATA0
    send_byte(8'hC3);
    send_byte(8'h00);
    send_byte(8'h00);
    send_eop();
    check_result("data0_zlp", 24, 1'b1, 3'd0);
    accept("data0_zlp");

    // PID D3: nPID mismatch, length otherwise acceptable for data class
    send_byte(8'hD3);
    send_byte(8'h00);
    send_byte(8'h00);
    send_eop();
    check_result("bad_pid", 24, 1'b0, 3'd1);
    accept("bad_pid");

    // 9-bit packet
    send_byte(8'hD2);
    send_bit(1'b0);
    send_eop();
    check_result("len9", 9, 1'b0, 3'd3);
    accept("len9");

    // DATA0 with 9 payload bytes: overflow, length saturates at buffer size
    send_byte(8'hC3);
    for (int i = 1; i <= 9; i++) send_byte(8'(i));
    send_byte(8'h00);
    send_byte(8'h00);
    send_eop();
    check_result("ovf", 88, 1'b0, 3'd4);
    accept("ovf");

    // Held output: bits offered while out_ready=0 are dropped
    send_byte(8'hD2);
    send_eop();
    bus.bit_in       = 1'b1;
    bus.bit_in_avail = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_result("hold", 8, 1'b1, 3'd0);
    end
    bus.bit_in_avail = 1'b0;
    bus.bit_in       = 1'b0;
    accept("hold");
    send_byte(8'h2D);
    send_byte(8'h00);
    send_byte(8'h10);
    send_eop();
    check_result("after_hold", 24, 1'b1, 3'd0);
    accept("after_hold");

    // Reset in the middle of a DATA packet after 30 bits
    send_byte(8'hC3);
    send_byte(8'h80);
    send_byte(8'h06);
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("mid_rst");
    exp_pkt = '0;
    exp_len = 0;
    send_byte(8'hD2);
    send_eop();
    check_result("post_rst_ack", 8, 1'b1, 3'd0);
    accept("post_rst_ack");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
